// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, execute-stage state encoding and
// a small op-classification helper used by the decoder and the execute stage.
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Both shift codes share the 11x prefix; bit 0 selects the direction.
   function automatic logic is_shift(input logic [2:0] op);
      return op[2] & op[1];
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational add/sub/and/or/xor/slt datapath with adder carry-out and
// signed overflow. Shift codes produce zero here; the execute stage owns shifts.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow
);

   logic             sub_op;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic             sum_ovf;
   logic             less;

   assign sub_op  = (alu_control == ALU_SUB) || (alu_control == ALU_SLT);
   assign b_eff   = sub_op ? ~b : b;
   assign sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
   // Overflow when a and the effective (possibly inverted) b agree in sign but the sum does not.
   assign sum_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   assign less    = sum[WIDTH-1] ^ sum_ovf;

   always_comb begin
      result   = '0;
      carry    = 1'b0;
      overflow = 1'b0;
      case (alu_control)
         ALU_ADD, ALU_SUB: begin
            result   = sum[WIDTH-1:0];
            carry    = sum[WIDTH];
            overflow = sum_ovf;
         end
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_SLT: result = {{(WIDTH-1){1'b0}}, less};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_exec_stage.sv
// Handshaked execute stage: single-cycle ALU ops via alu_core, iterative
// one-bit-per-cycle logical shifts, registered result and flags.
//
// state | meaning
// IDLE  | ready for a new op, no result pending
// SHIFT | shifting one position per cycle, count holds remaining steps
// DONE  | result and flags valid, held until consumed
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             overflow
);

   localparam int SHW = $clog2(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_next;
   logic [SHW-1:0]   count;
   logic [SHW-1:0]   shamt;
   logic             shift_right;
   logic             accept;
   logic [WIDTH-1:0] core_result;
   logic [WIDTH-1:0] imm_result;
   logic             core_carry;
   logic             core_overflow;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .alu_control (alu_control),
      .a           (src_a),
      .b           (src_b),
      .result      (core_result),
      .carry       (core_carry),
      .overflow    (core_overflow)
   );

   assign in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept     = in_valid && in_ready;
   assign shamt      = src_b[SHW-1:0];
   assign shreg_next = shift_right ? (shreg >> 1) : (shreg << 1);
   // A zero-distance shift completes immediately with src_a unchanged.
   assign imm_result = is_shift(alu_control) ? src_a : core_result;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         out_valid   <= 1'b0;
         result      <= '0;
         zero        <= 1'b0;
         carry       <= 1'b0;
         overflow    <= 1'b0;
         shreg       <= '0;
         count       <= '0;
         shift_right <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  if (is_shift(alu_control) && (shamt != '0)) begin
                     state       <= SHIFT;
                     out_valid   <= 1'b0;
                     shreg       <= src_a;
                     count       <= shamt;
                     shift_right <= alu_control[0];
                  end else begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     result    <= imm_result;
                     zero      <= (imm_result == '0);
                     carry     <= core_carry;
                     overflow  <= core_overflow;
                  end
               end else if ((state == DONE) && out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            SHIFT: begin
               shreg <= shreg_next;
               count <= count - SHW'(1);
               if (count == SHW'(1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  result    <= shreg_next;
                  zero      <= (shreg_next == '0);
                  carry     <= 1'b0;
                  overflow  <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: hand-computed vectors, latency,
// back-pressure, back-to-back and reset-abort scenarios.
module tb_alu_exec_stage;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;
   localparam logic [2:0] OP_SLL = 3'b110;
   localparam logic [2:0] OP_SRL = 3'b111;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  alu_control;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        carry;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_exec_stage #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_control (alu_control),
      .src_a       (src_a),
      .src_b       (src_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .carry       (carry),
      .overflow    (overflow)
   );

   // Drive an op at a negedge, let the accept edge pass, return at the next negedge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      in_valid    = 1'b1;
      alu_control = op;
      src_a       = a;
      src_b       = b;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      alu_control = OP_ADD; src_a = '0; src_b = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid, result, zero, carry, overflow} !== 36'h0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b result=%h z=%b c=%b v=%b, want all 0",
                  out_valid, result, zero, carry, overflow);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_add_overflow();
      issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL add_latency: out_valid got %b want 1 one cycle after accept", out_valid);
      end
      checks++;
      if ({result, zero, carry, overflow} !== {32'h8000_0000, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL add_ovf: got %h z=%b c=%b v=%b want 80000000 z=0 c=0 v=1",
                  result, zero, carry, overflow);
      end
      consume();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL add_consume: out_valid got %b want 0", out_valid);
      end
   endtask

   task automatic test_single_cycle_ops();
      issue(OP_SUB, 32'd5, 32'd5);
      checks++;
      if ({out_valid, result, zero, carry, overflow} !== {1'b1, 32'h0, 1'b1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL sub_zero: got v=%b %h z=%b c=%b o=%b want v=1 0 z=1 c=1 o=0",
                  out_valid, result, zero, carry, overflow);
      end
      consume();
      issue(OP_SUB, 32'd3, 32'd5);
      checks++;
      if ({result, zero, carry, overflow} !== {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL sub_borrow: got %h z=%b c=%b o=%b want fffffffe z=0 c=0 o=0",
                  result, zero, carry, overflow);
      end
      consume();
      issue(OP_SLT, 32'hFFFF_FFFF, 32'd1);
      checks++;
      if ({result, carry, overflow} !== {32'h1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL slt_neg: got %h c=%b o=%b want 1 c=0 o=0", result, carry, overflow);
      end
      consume();
      issue(OP_SLT, 32'd7, 32'hFFFF_FFF0);
      checks++;
      if ({result, zero} !== {32'h0, 1'b1}) begin
         errors++; $display("FAIL slt_pos: got %h z=%b want 0 z=1", result, zero);
      end
      consume();
      issue(OP_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0);
      checks++;
      if ({result, carry, overflow} !== {32'hF0F0_F0F0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL xor: got %h c=%b o=%b want f0f0f0f0 c=0 o=0", result, carry, overflow);
      end
      consume();
      issue(OP_ADD, 32'hFFFF_FFFF, 32'd1);
      checks++;
      if ({result, zero, carry, overflow} !== {32'h0, 1'b1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL add_carry: got %h z=%b c=%b o=%b want 0 z=1 c=1 o=0",
                  result, zero, carry, overflow);
      end
      consume();
   endtask

   task automatic test_shift();
      int lat;
      int busy_bad;
      // SLL by 4: latency 5, stalled input in between.
      issue(OP_SLL, 32'h1, 32'd4);
      lat = 1; busy_bad = 0;
      while (!out_valid && lat < 100) begin
         if (in_ready !== 1'b0) busy_bad++;
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != 5 || busy_bad != 0) begin
         errors++; $display("FAIL sll_latency: got lat=%0d busy_ready=%0d want lat=5 busy_ready=0", lat, busy_bad);
      end
      checks++;
      if ({result, zero, carry, overflow} !== {32'h10, 1'b0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL sll_result: got %h z=%b c=%b o=%b want 00000010 0 0 0", result, zero, carry, overflow);
      end
      consume();
      // SRL by 31: maximum latency 32.
      issue(OP_SRL, 32'h8000_0000, 32'd31);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != 32 || result !== 32'h1) begin
         errors++; $display("FAIL srl_max: got lat=%0d result=%h want lat=32 result=00000001", lat, result);
      end
      consume();
      // Zero-distance shift completes in one cycle; upper src_b bits ignored.
      issue(OP_SLL, 32'hABCD_0123, 32'hFFFF_FFE0);
      checks++;
      if (out_valid !== 1'b1 || result !== 32'hABCD_0123) begin
         errors++; $display("FAIL sll_k0: got valid=%b result=%h want valid=1 result=abcd0123", out_valid, result);
      end
      consume();
      // Shift everything out: zero flag from the final result.
      issue(OP_SRL, 32'h0000_0003, 32'd2);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != 3 || result !== 32'h0 || zero !== 1'b1) begin
         errors++; $display("FAIL srl_zero: got lat=%0d result=%h z=%b want lat=3 result=0 z=1", lat, result, zero);
      end
      consume();
   endtask

   task automatic test_backpressure();
      int unstable;
      issue(OP_AND, 32'h0000_F0F0, 32'h0000_FF00);
      unstable = 0;
      repeat (3) begin
         if (out_valid !== 1'b1 || result !== 32'h0000_F000 || zero !== 1'b0 || in_ready !== 1'b0)
            unstable++;
         @(negedge clk);
      end
      checks++;
      if (unstable != 0 || result !== 32'h0000_F000) begin
         errors++; $display("FAIL bp_hold: got %0d bad cycles result=%h want 0 bad result=0000f000", unstable, result);
      end
      out_ready = 1'b1;
      in_valid = 1'b1; alu_control = OP_OR; src_a = 32'd1; src_b = 32'd2;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_ready: in_ready got %b want 1 with out_ready=1 in DONE", in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || result !== 32'h3) begin
         errors++; $display("FAIL bp_b2b: got valid=%b result=%h want valid=1 result=00000003", out_valid, result);
      end
      consume();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      in_valid = 1'b1; alu_control = OP_ADD; src_a = 32'd1; src_b = 32'd1;
      @(posedge clk); @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== 32'd2 || in_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_first: got valid=%b result=%h ready=%b want 1 2 1", out_valid, result, in_ready);
      end
      src_a = 32'd2; src_b = 32'd2;
      @(posedge clk); @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== 32'd4) begin
         errors++; $display("FAIL b2b_second: got valid=%b result=%h want 1 4", out_valid, result);
      end
      in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_drain: out_valid got %b want 0", out_valid);
      end
   endtask

   task automatic test_reset_mid_shift();
      int seen;
      int lat;
      issue(OP_SRL, 32'h0000_1234, 32'd20);
      repeat (4) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
         errors++; $display("FAIL rst_shift: got valid=%b ready=%b result=%h want 0 1 0", out_valid, in_ready, result);
      end
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL rst_no_result: out_valid high %0d cycles, want 0", seen);
      end
      issue(OP_ADD, 32'd2, 32'd3);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != 1 || result !== 32'd5) begin
         errors++; $display("FAIL rst_recover: got lat=%0d result=%h want lat=1 result=5", lat, result);
      end
      consume();
   endtask

   task automatic test_reset_in_done();
      issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({out_valid, result, zero, carry, overflow} !== 36'h0) begin
         errors++;
         $display("FAIL rst_done: got valid=%b result=%h z=%b c=%b v=%b want all 0",
                  out_valid, result, zero, carry, overflow);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL rst_done_idle: got valid=%b ready=%b want 0 1", out_valid, in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_single_cycle_ops();
      test_shift();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_shift();
      test_reset_in_done();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered, handshaked execute stage that consumes the 3-bit ALU control code from the ALU decoder, together with two operands, and returns a result plus condition flags. Single-cycle operations (add, sub, and, or, xor, slt) complete in one cycle. Shifts (sll, srl) iterate one bit position per cycle. The block sits directly downstream of the ALU decoder and replaces the purely combinational ALU wherever operands arrive through a valid/ready interface.

## Interface
- WIDTH, 32, operand and result width in bits
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request valid
- in_ready  out  1  stage can accept an operation this cycle
- alu_control  in  3  operation code (encoding under Operation)
- src_a  in  WIDTH  operand A (shift source for sll/srl)
- src_b  in  WIDTH  operand B; for sll/srl only bits [SHW-1:0] are used
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer takes the result this cycle
- result  out  WIDTH  operation result
- zero  out  1  result == 0
- carry  out  1  carry out of the adder; add/sub only, else 0
- overflow  out  1  signed overflow; add/sub only, else 0

## Operation
- Encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL.
- The decoder's existing codes (000/001/010/011/101) are unchanged. Codes 100, 110 and 111 are new.
- Accept: in_valid && in_ready on a rising edge. Operands and code are captured at that edge. Inputs are ignored at all other times.
- ADD: a+b.
- SUB: a+~b+1. carry = carry-out of that sum, so carry=1 means no borrow.
- Overflow (add/sub): set when the operands have the same effective sign and the result sign differs.
- SLT: result = {0…, signed(a)<signed(b)}. Computed from the sub path; carry and overflow forced to 0.
- SLL/SRL: logical shift of src_a by k = src_b[SHW-1:0], one bit per cycle. Vacated bits are filled with 0.
- zero is always computed from the final result.
- State machine: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1, out_valid=0.
    - Accept of a non-shift op, or of a shift with k=0 → DONE, with the result registered at the accept edge.
    - Accept of a shift with k>0 → SHIFT, with shift register=src_a and count=k.
  - SHIFT: in_ready=0, out_valid=0. Each edge shifts one position and decrements count. When count reaches 0 → DONE.
  - DONE: out_valid=1; result and flags held stable.
    - out_ready=0: stay in DONE.
    - out_ready=1 and no accept → IDLE.
    - out_ready=1 and in_valid=1: the result is consumed and a new op is accepted at the same edge. Next state follows the IDLE accept rules (back-to-back).
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is combinational from state and out_ready; there is no combinational path from in_valid.
- All outputs are registered except in_ready.

## Timing
- Reset (asynchronous assert, synchronous deassert expected from the system):
  - state=IDLE
  - out_valid=0, result=0, zero=0, carry=0, overflow=0, shift count=0
- While reset is high, handshakes are ignored.
- Latency, counted from the accept edge to the first edge where out_valid=1 is sampled:
  - non-shift ops and k=0 shifts: 1 cycle
  - shifts with k>0: 1+k cycles
- Maximum shift latency is WIDTH cycles (k=WIDTH-1).
- Throughput:
  - one non-shift op per cycle when out_ready is held high
  - shifts block new accepts until DONE
- Reset mid-operation (SHIFT or DONE): the operation is discarded. out_valid drops immediately (asynchronously) and the stage returns to IDLE. No result is delivered.
- Back-pressure: while out_valid=1 && out_ready=0, result, zero, carry and overflow must not change.

## Structure
- Shared package alu_pkg holds:
  - the 3-bit op-code localparams (ALU_ADD … ALU_SRL)
  - the state enum (IDLE/SHIFT/DONE)
- The ALU decoder is updated to import the same package.
- One sub-module, alu_core: combinational add/sub/and/or/xor/slt with carry and overflow.
- alu_exec_stage instantiates alu_core and owns the FSM, the shift register/counter and the output registers.

## Test plan
- Reset: assert reset mid-run → out_valid=0, result=0, all flags 0, in_ready=1 after deassert.
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow=1, carry=0, zero=0; out_valid 1 cycle after accept.
- SUB 5 − 5 → result 0, zero=1, carry=1, overflow=0.
- SLT 0xFFFFFFFF vs 1 → result 1.
- SLL 0x00000001 by 4 → result 0x00000010; out_valid 5 cycles after accept; in_ready=0 in between.
- SRL 0x80000000 by 31 → result 1 after 32 cycles.
- Back-pressure: hold out_ready=0 for 3 cycles after an AND 0xF0F0 & 0xFF00 → result 0xF000 stable and in_ready=0. Then raise out_ready with in_valid=1 (OR 1|2) → ADD… new op accepted the same edge, next out_valid with result 3.
- Reset during SRL of 0x1234 by 20, asserted 5 cycles after accept → out_valid never rises, state IDLE, next ADD 2+3 returns 5 with latency 1.
